// File: rtl/rf_bypass_read_port_if.sv
// Bundle of write-port and dual read-port signals between decode/writeback and the register file.
interface rf_bypass_read_port_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              stall;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              byp_a;
    logic              byp_b;

    modport master (
        output wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b, stall,
        input  rd_valid, rd_data_a, rd_data_b, byp_a, byp_b
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_req, rd_addr_a, rd_addr_b, stall,
        output rd_valid, rd_data_a, rd_data_b, byp_a, byp_b
    );
endinterface

// File: rtl/rf_bypass_read_port.sv
// Register file with two registered read ports, write-before-read bypass,
// and held results that track writes to their index while stalled.
module rf_read_lane #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              stall,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ok,
    input  logic [DATA_W-1:0] rd_word,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              byp
);
    logic [ADDR_W-1:0] held;

    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
            data <= '0;
            byp  <= 1'b0;
        end else if (stall) begin
            // wr_ok already excludes r0/out-of-range, so an invalid held index never matches
            if (wr_ok && wr_addr == held) begin
                data <= wr_data;
                byp  <= 1'b1;
            end
        end else if (accept) begin
            held <= rd_addr;
            if (!rd_ok) begin
                data <= '0;
                byp  <= 1'b0;
            end else if (wr_ok && wr_addr == rd_addr) begin
                data <= wr_data;
                byp  <= 1'b1;
            end else begin
                data <= rd_word;
                byp  <= 1'b0;
            end
        end
    end
endmodule

module rf_bypass_read_port #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int R0_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    rf_bypass_read_port_if.slave  rf
);
    localparam int NUM_PORTS = 2;

    // Index names a real, writable/readable register (not hardwired r0, not past the file)
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) && !((R0_ZERO != 0) && (a == '0));
    endfunction

    logic [DATA_W-1:0]                 mem [NUM_REGS];
    logic                              wr_ok;
    logic                              accept;
    logic                              rd_valid;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  rd_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  rd_data;
    logic [NUM_PORTS-1:0]              byp;

    assign wr_ok   = rf.wr_en && addr_ok(rf.wr_addr);
    assign accept  = rf.rd_req && !rf.stall;
    assign rd_addr = {rf.rd_addr_b, rf.rd_addr_a};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[rf.wr_addr] <= rf.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          rd_valid <= 1'b0;
        else if (!rf.stall) rd_valid <= rf.rd_req;
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        logic              ok;
        logic [DATA_W-1:0] word;

        assign ok   = addr_ok(rd_addr[g]);
        assign word = ok ? mem[rd_addr[g]] : '0;

        rf_read_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .accept  (accept),
            .stall   (rf.stall),
            .rd_addr (rd_addr[g]),
            .rd_ok   (ok),
            .rd_word (word),
            .wr_ok   (wr_ok),
            .wr_addr (rf.wr_addr),
            .wr_data (rf.wr_data),
            .data    (rd_data[g]),
            .byp     (byp[g])
        );
    end

    assign rf.rd_valid  = rd_valid;
    assign rf.rd_data_a = rd_data[0];
    assign rf.rd_data_b = rd_data[1];
    assign rf.byp_a     = byp[0];
    assign rf.byp_b     = byp[1];
endmodule

// File: tb/tb_rf_bypass_read_port.sv
// Bench: directed scenarios plus random traffic, every cycle compared to a register-file model.
module tb_rf_bypass_read_port;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_bypass_read_port_if #(.DATA_W(16), .ADDR_W(4)) intf ();

    rf_bypass_read_port #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .R0_ZERO(1)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (intf.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model state: architectural registers and what each read port must show
    logic [15:0] m_reg [16];
    logic        m_valid;
    logic [15:0] m_data [2];
    logic        m_byp [2];
    int          m_held [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        int  wa;
        bit  wv;
        int  ra [2];
        wa = int'(intf.wr_addr);
        wv = intf.wr_en && wa != 0;
        ra[0] = int'(intf.rd_addr_a);
        ra[1] = int'(intf.rd_addr_b);
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 16'h0;
            m_valid = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_data[p] = 16'h0; m_byp[p] = 1'b0; m_held[p] = 0;
            end
            return;
        end
        if (intf.stall) begin
            for (int p = 0; p < 2; p++)
                if (wv && wa == m_held[p]) begin
                    m_data[p] = intf.wr_data; m_byp[p] = 1'b1;
                end
        end else if (intf.rd_req) begin
            m_valid = 1'b1;
            for (int p = 0; p < 2; p++) begin
                m_held[p] = ra[p];
                if (ra[p] == 0) begin
                    m_data[p] = 16'h0; m_byp[p] = 1'b0;
                end else if (wv && wa == ra[p]) begin
                    m_data[p] = intf.wr_data; m_byp[p] = 1'b1;
                end else begin
                    m_data[p] = m_reg[ra[p]]; m_byp[p] = 1'b0;
                end
            end
        end else begin
            m_valid = 1'b0;
        end
        if (wv) m_reg[wa] = intf.wr_data;
    endtask

    task automatic drive(input bit r, input bit we, input int wa, input logic [15:0] wd,
                         input bit rq, input int aa, input int ab, input bit st);
        rst            = r;
        intf.wr_en     = we;
        intf.wr_addr   = 4'(wa);
        intf.wr_data   = wd;
        intf.rd_req    = rq;
        intf.rd_addr_a = 4'(aa);
        intf.rd_addr_b = 4'(ab);
        intf.stall     = st;
    endtask

    // One clock: model steps on the driven inputs, DUT compared on the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("rd_valid", 32'(intf.rd_valid), 32'(m_valid));
        chk("rd_data_a", 32'(intf.rd_data_a), 32'(m_data[0]));
        chk("rd_data_b", 32'(intf.rd_data_b), 32'(m_data[1]));
        chk("byp_a", 32'(intf.byp_a), 32'(m_byp[0]));
        chk("byp_b", 32'(intf.byp_b), 32'(m_byp[1]));
    endtask

    initial begin
        foreach (m_reg[i]) m_reg[i] = 16'h0;
        m_valid = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_data[p] = 16'h0; m_byp[p] = 1'b0; m_held[p] = 0;
        end

        // 1: reset then first read of empty registers
        drive(1, 0, 0, 16'h0, 0, 0, 0, 0); tick(); tick();
        chk("t1_rst_valid", 32'(intf.rd_valid), 32'd0);
        drive(0, 0, 0, 16'h0, 1, 3, 5, 0); tick();
        chk("t1_valid", 32'(intf.rd_valid), 32'd1);
        chk("t1_a", 32'(intf.rd_data_a), 32'h0000);
        chk("t1_b", 32'(intf.rd_data_b), 32'h0000);

        // 2: write then later read, no bypass
        drive(0, 1, 3, 16'hBEEF, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 16'h0, 1, 3, 0, 0); tick();
        chk("t2_a", 32'(intf.rd_data_a), 32'hBEEF);
        chk("t2_byp_a", 32'(intf.byp_a), 32'd0);

        // 3: same-edge write forwards to both ports
        drive(0, 1, 7, 16'h1234, 1, 7, 7, 0); tick();
        chk("t3_a", 32'(intf.rd_data_a), 32'h1234);
        chk("t3_b", 32'(intf.rd_data_b), 32'h1234);
        chk("t3_byp", {30'd0, intf.byp_a, intf.byp_b}, 32'd3);
        drive(0, 0, 0, 16'h0, 1, 7, 7, 0); tick();
        chk("t3_later_a", 32'(intf.rd_data_a), 32'h1234);
        chk("t3_later_byp", 32'(intf.byp_a), 32'd0);

        // 4: r0 hardwired, r15 normal
        drive(0, 1, 0, 16'hFFFF, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 16'h0, 1, 0, 0, 0); tick();
        chk("t4_r0", 32'(intf.rd_data_a), 32'h0000);
        drive(0, 1, 15, 16'hA5A5, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 16'h0, 1, 0, 15, 0); tick();
        chk("t4_r15", 32'(intf.rd_data_b), 32'hA5A5);

        // 5: held result tracks writes over a multi-cycle stall
        drive(0, 1, 2, 16'h0002, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 16'h0, 1, 2, 0, 0); tick();
        chk("t5_a0", 32'(intf.rd_data_a), 32'h0002);
        drive(0, 1, 2, 16'h1111, 0, 0, 0, 1); tick();
        drive(0, 1, 2, 16'h2222, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 16'h0, 1, 4, 0, 1); tick();
        chk("t5_a", 32'(intf.rd_data_a), 32'h2222);
        chk("t5_byp_a", 32'(intf.byp_a), 32'd1);
        chk("t5_valid", 32'(intf.rd_valid), 32'd1);

        // 6: reset beats a same-cycle read and write
        drive(0, 1, 1, 16'h4321, 1, 1, 2, 0); tick();
        drive(1, 1, 1, 16'h9999, 1, 1, 1, 0); tick();
        chk("t6_valid", 32'(intf.rd_valid), 32'd0);
        chk("t6_a", 32'(intf.rd_data_a), 32'h0000);
        chk("t6_byp", {30'd0, intf.byp_a, intf.byp_b}, 32'd0);
        drive(0, 0, 0, 16'h0, 1, 1, 1, 0); tick();
        chk("t6_r1", 32'(intf.rd_data_a), 32'h0000);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 2,
                  $urandom_range(0, 1),
                  int'($urandom_range(0, 15)),
                  16'($urandom),
                  $urandom_range(0, 99) < 60,
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 30);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
